// File: rtl/clock_pkg.sv
// Shared definitions for the BCD HH:MM:SS clock blocks: digit limits,
// field positions inside the 24-bit packed time word, and the timer state type.
package clock_pkg;

    localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
    localparam logic [3:0] BCD_HOUR_TENS_MAX = 4'd2;

    localparam int TIME_DIGITS = 6;
    localparam int TIME_W      = 4 * TIME_DIGITS;

    // Digit index inside the packed word; bit offset is index*4
    localparam int SEC_ONES  = 0;
    localparam int SEC_TENS  = 1;
    localparam int MIN_ONES  = 2;
    localparam int MIN_TENS  = 3;
    localparam int HOUR_ONES = 4;
    localparam int HOUR_TENS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    // Value a digit takes when it borrows from zero
    function automatic logic [3:0] digit_wrap(input int idx);
        logic [3:0] w;
        case (idx)
            SEC_TENS, MIN_TENS: w = BCD_SEC_TENS_MAX;
            HOUR_TENS:          w = BCD_HOUR_TENS_MAX;
            default:            w = BCD_DIGIT_MAX;
        endcase
        return w;
    endfunction

    // Legal duration: all nibbles decimal, tens of sec/min below 6, hours bounded
    function automatic logic bcd_time_valid(input logic [TIME_W-1:0] v,
                                            input logic [7:0] max_hh);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (v[i*4 +: 4] > BCD_DIGIT_MAX)
                ok = 1'b0;
        end
        if (v[SEC_TENS*4 +: 4] > BCD_SEC_TENS_MAX)
            ok = 1'b0;
        if (v[MIN_TENS*4 +: 4] > BCD_SEC_TENS_MAX)
            ok = 1'b0;
        if (v[HOUR_ONES*4 +: 8] > max_hh)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain: decrements when a borrow
// arrives and wraps to wrap_value when it is already zero.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] wrap_value,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = wrap_value;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD HH:MM:SS countdown timer with load validation, start/pause control,
// expiry pulse, sticky alarm and optional auto-reload of the last duration.
module bcd_countdown_timer
    import clock_pkg::*;
#(
    parameter bit         AUTO_RELOAD = 1'b0,
    parameter logic [7:0] MAX_HH      = 8'h23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        pause,
    input  logic        ack,
    output logic [23:0] hexs,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        load_err
);

    timer_state_t state_reg, state_next;
    logic [23:0] hexs_reg, hexs_next;
    logic [23:0] reload_reg, reload_next;
    logic        running_reg, running_next;
    logic        done_reg, done_next;
    logic        alarm_reg, alarm_next;
    logic        load_err_reg, load_err_next;

    logic [23:0]            dec_val;
    logic [TIME_DIGITS:0]   borrow;
    logic                   hexs_zero;
    logic                   load_ok;
    logic                   at_last_second;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < TIME_DIGITS; gi++) begin : g_digit
            bcd_digit_dec u_dec (
                .digit      (hexs_reg[gi*4 +: 4]),
                .wrap_value (digit_wrap(gi)),
                .borrow_in  (borrow[gi]),
                .next_digit (dec_val[gi*4 +: 4]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    // A borrow escaping the hour-tens digit means every digit was zero
    assign hexs_zero      = borrow[TIME_DIGITS];
    assign load_ok        = bcd_time_valid(load_val, MAX_HH);
    assign at_last_second = (hexs_reg == 24'h000001);

    always_comb begin
        state_next    = state_reg;
        hexs_next     = hexs_reg;
        reload_next   = reload_reg;
        done_next     = 1'b0;
        load_err_next = 1'b0;
        alarm_next    = alarm_reg;

        if (ack)
            alarm_next = 1'b0;

        // One strobe acts per cycle; ack's alarm clear above is never dropped
        if (load) begin
            if (load_ok) begin
                hexs_next   = load_val;
                reload_next = load_val;
                state_next  = IDLE;
                alarm_next  = 1'b0;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (pause) begin
            if (state_reg == RUN)
                state_next = PAUSED;
        end else if (start) begin
            if ((state_reg == IDLE || state_reg == PAUSED) && !hexs_zero)
                state_next = RUN;
        end else if (ack) begin
            state_next = state_reg;
        end else if (tick && state_reg == RUN) begin
            if (at_last_second) begin
                done_next  = 1'b1;
                alarm_next = 1'b1;
                if (AUTO_RELOAD && reload_reg != 24'h000000) begin
                    hexs_next = reload_reg;
                end else begin
                    hexs_next  = 24'h000000;
                    state_next = EXPIRED;
                end
            end else begin
                hexs_next = dec_val;
            end
        end

        running_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hexs_reg     <= 24'h000000;
            reload_reg   <= 24'h000000;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
            alarm_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hexs_reg     <= hexs_next;
            reload_reg   <= reload_next;
            running_reg  <= running_next;
            done_reg     <= done_next;
            alarm_reg    <= alarm_next;
            load_err_reg <= load_err_next;
        end
    end

    assign hexs     = hexs_reg;
    assign running  = running_reg;
    assign done     = done_reg;
    assign alarm    = alarm_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed-vector bench for bcd_countdown_timer: one instance per AUTO_RELOAD
// setting, driven from the same strobes and checked one cycle per vector.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
    logic [23:0] load_val = 24'h0;

    logic [23:0] h0, h1;
    logic        r0, d0, a0, e0;
    logic        r1, d1, a1, e1;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0), .MAX_HH(8'h23)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .ack(ack),
        .hexs(h0), .running(r0), .done(d0), .alarm(a0), .load_err(e0)
    );

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1), .MAX_HH(8'h23)) dut_ar (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .ack(ack),
        .hexs(h1), .running(r1), .done(d1), .alarm(a1), .load_err(e1)
    );

    typedef struct {
        logic        ld;
        logic [23:0] lv;
        logic        st, pa, ak, tk;
        logic [23:0] e_hexs;
        logic        e_run, e_done, e_alarm, e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic ld, input logic [23:0] lv,
                                input logic st, input logic pa, input logic ak,
                                input logic tk, input logic [23:0] eh,
                                input logic erun, input logic edn,
                                input logic eal, input logic eer);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.ak = ak; v.tk = tk;
        v.e_hexs = eh; v.e_run = erun; v.e_done = edn; v.e_alarm = eal; v.e_err = eer;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [23:0] hx, input logic run,
                         input logic dn, input logic al, input logic er,
                         input logic [23:0] eh, input logic erun, input logic edn,
                         input logic eal, input logic eer);
        n_vec++;
        if ({hx, run, dn, al, er} !== {eh, erun, edn, eal, eer}) begin
            n_bad++;
            $display("FAIL %s: got hexs=%06h run=%b done=%b alarm=%b err=%b, need hexs=%06h run=%b done=%b alarm=%b err=%b",
                     name, hx, run, dn, al, er, eh, erun, edn, eal, eer);
        end else begin
            $display("ok   %s: hexs=%06h run=%b done=%b alarm=%b err=%b",
                     name, hx, run, dn, al, er);
        end
    endtask

    // Called on a falling edge: hold strobes across one rising edge, then release
    task automatic drive(input logic ld, input logic [23:0] lv, input logic st,
                         input logic pa, input logic ak, input logic tk);
        load = ld; load_val = lv; start = st; pause = pa; ack = ak; tick = tk;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0; tick = 1'b0;
    endtask

    initial begin
        int secs;
        logic [23:0] eh;

        //          ld  load_val    st pa ak tk  hexs       run done alm err
        vecs.push_back(mk(1, 24'h100000, 0, 0, 0, 0, 24'h100000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h100000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h095959, 1, 0, 0, 0));
        vecs.push_back(mk(1, 24'h230000, 0, 0, 0, 0, 24'h230000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 24'h240000, 0, 0, 0, 0, 24'h230000, 0, 0, 0, 1));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 0, 24'h230000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 24'h006000, 0, 0, 0, 0, 24'h230000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 24'h00000A, 0, 0, 0, 0, 24'h230000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 24'h000010, 0, 0, 0, 0, 24'h000010, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000010, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000009, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000008, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000007, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 1, 0, 0, 24'h000007, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000007, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000007, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000006, 1, 0, 0, 0));
        vecs.push_back(mk(1, 24'h000300, 0, 0, 0, 1, 24'h000300, 0, 0, 0, 0));
        vecs.push_back(mk(1, 24'h000000, 0, 0, 0, 0, 24'h000000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 24'h010000, 0, 0, 0, 0, 24'h010000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h010000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h005959, 1, 0, 0, 0));
        vecs.push_back(mk(1, 24'h000001, 0, 0, 0, 0, 24'h000001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 0, 24'h000000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 1, 0));
        vecs.push_back(mk(1, 24'h000002, 0, 0, 0, 0, 24'h000002, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 24'h000000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 0, 0));

        // Power-on reset
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", h0, r0, d0, a0, e0, 24'h0, 0, 0, 0, 0);
        check("reset_ar", h1, r1, d1, a1, e1, 24'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].ak, vecs[i].tk);
            check($sformatf("vec%0d", i), h0, r0, d0, a0, e0,
                  vecs[i].e_hexs, vecs[i].e_run, vecs[i].e_done, vecs[i].e_alarm, vecs[i].e_err);
        end

        // 1:05 countdown through the minute borrow down to expiry
        drive(1, 24'h000105, 0, 0, 0, 0);
        drive(0, 24'h0, 1, 0, 0, 0);
        check("cd_start", h0, r0, d0, a0, e0, 24'h000105, 1, 0, 0, 0);
        for (int k = 1; k <= 65; k++) begin
            drive(0, 24'h0, 0, 0, 0, 1);
            secs = 65 - k;
            eh = {8'h00, to_bcd(secs / 60), to_bcd(secs % 60)};
            check($sformatf("cd_tick%0d", k), h0, r0, d0, a0, e0,
                  eh, (k < 65), (k == 65), (k == 65), 1'b0);
        end
        drive(0, 24'h0, 0, 0, 0, 0);
        check("cd_done_once", h0, r0, d0, a0, e0, 24'h0, 0, 0, 1, 0);
        drive(0, 24'h0, 1, 0, 0, 0);
        check("cd_start_expired", h0, r0, d0, a0, e0, 24'h0, 0, 0, 1, 0);

        // Asynchronous reset while running, asserted between clock edges
        drive(1, 24'h123456, 0, 0, 0, 0);
        drive(0, 24'h0, 1, 0, 0, 0);
        drive(0, 24'h0, 0, 0, 0, 1);
        check("pre_rst", h0, r0, d0, a0, e0, 24'h123455, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("async_rst", h0, r0, d0, a0, e0, 24'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", h0, r0, d0, a0, e0, 24'h0, 0, 0, 0, 0);

        // Auto-reload instance: 2 s period keeps running and pulses done each expiry
        drive(1, 24'h000002, 0, 0, 0, 0);
        check("ar_load", h1, r1, d1, a1, e1, 24'h000002, 0, 0, 0, 0);
        drive(0, 24'h0, 1, 0, 0, 0);
        check("ar_start", h1, r1, d1, a1, e1, 24'h000002, 1, 0, 0, 0);
        drive(0, 24'h0, 0, 0, 0, 1);
        check("ar_tick1", h1, r1, d1, a1, e1, 24'h000001, 1, 0, 0, 0);
        drive(0, 24'h0, 0, 0, 0, 1);
        check("ar_tick2", h1, r1, d1, a1, e1, 24'h000002, 1, 1, 1, 0);
        drive(0, 24'h0, 0, 0, 0, 1);
        check("ar_tick3", h1, r1, d1, a1, e1, 24'h000001, 1, 0, 1, 0);
        drive(0, 24'h0, 0, 0, 0, 1);
        check("ar_tick4", h1, r1, d1, a1, e1, 24'h000002, 1, 1, 1, 0);
        drive(0, 24'h0, 0, 0, 1, 0);
        check("ar_ack", h1, r1, d1, a1, e1, 24'h000002, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
